// File: rtl/fpu_issue_ctrl.sv
// FPU request initiator: issue/wait tracking stages, credit-based response FIFO, sticky error flag.
// Optional counters stat_issued/stat_error/stat_ovf are built when FPU_ISSUE_STATS_EN is defined.
`timescale 1ns/1ps
module fpu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [1:0]       req_rm,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_sel,
  output logic [1:0]       fpu_rm,
  output logic             fpu_start,
  input  logic [31:0]      fpu_y,
  input  logic             fpu_error,
  input  logic             fpu_overflow,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_y,
  output logic             resp_error,
  output logic             resp_overflow,
  output logic [TAG_W-1:0] resp_tag,
  output logic             sticky_err,
  input  logic             clr_sticky
`ifdef FPU_ISSUE_STATS_EN
  ,
  output logic [15:0]      stat_issued,
  output logic [15:0]      stat_error,
  output logic [15:0]      stat_ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 34 + TAG_W;
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic [AW+1:0]    credit_s;
  logic [EW-1:0]    head_s;
  logic             s1_v_r;
  logic             s2_v_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic [TAG_W-1:0] s2_tag_r;
  logic [EW-1:0]    mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;

  // Handshakes and credits; in-flight entries reserve FIFO slots so a push never finds it full.
  always_comb begin
    credit_s      = {1'b0, count_r} + {{(AW+1){1'b0}}, s1_v_r} + {{(AW+1){1'b0}}, s2_v_r};
    req_ready     = (credit_s < DEPTH_W);
    accept_s      = req_valid && req_ready;
    push_s        = s2_v_r;
    resp_valid    = (count_r != {(AW+1){1'b0}});
    pop_s         = resp_valid && resp_ready;
    head_s        = mem_r[rd_ptr_r];
    resp_y        = head_s[EW-1 -: 32];
    resp_error    = head_s[TAG_W+1];
    resp_overflow = head_s[TAG_W];
    resp_tag      = head_s[TAG_W-1:0];
  end

  // Issue stage drives the FPU; wait stage tracks the cycle the FPU result lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpu_a     <= 32'd0;
      fpu_b     <= 32'd0;
      fpu_sel   <= 2'd0;
      fpu_rm    <= 2'd0;
      fpu_start <= 1'b0;
      s1_v_r    <= 1'b0;
      s1_tag_r  <= {TAG_W{1'b0}};
      s2_v_r    <= 1'b0;
      s2_tag_r  <= {TAG_W{1'b0}};
    end else begin
      fpu_start <= accept_s;
      s1_v_r    <= accept_s;
      if (accept_s) begin
        fpu_a    <= req_a;
        fpu_b    <= req_b;
        fpu_sel  <= req_op;
        fpu_rm   <= req_rm;
        s1_tag_r <= req_tag;
      end
      s2_v_r   <= s1_v_r;
      s2_tag_r <= s1_tag_r;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {fpu_y, fpu_error, fpu_overflow, s2_tag_r};
  end

  // Sticky error: a captured fault outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_err <= 1'b0;
    end else if (push_s && (fpu_error || fpu_overflow)) begin
      sticky_err <= 1'b1;
    end else if (clr_sticky) begin
      sticky_err <= 1'b0;
    end
  end

`ifdef FPU_ISSUE_STATS_EN
  // Event counters; clr_sticky outranks a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued <= 16'd0;
      stat_error  <= 16'd0;
      stat_ovf    <= 16'd0;
    end else if (clr_sticky) begin
      stat_issued <= 16'd0;
      stat_error  <= 16'd0;
      stat_ovf    <= 16'd0;
    end else begin
      if (accept_s)                stat_issued <= stat_issued + 16'd1;
      if (push_s && fpu_error)     stat_error  <= stat_error + 16'd1;
      if (push_s && fpu_overflow)  stat_ovf    <= stat_ovf + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Request-side initiator for the floating-point unit. Accepts tagged operation requests over a valid/ready handshake and drives the FPU's operand, opcode, rounding and `start` inputs. Tracks each in-flight operation through the FPU's one-cycle registered output and stores result, `error`, `overflow` and tag in a response FIFO drained by a second valid/ready handshake. Sits between the core's dispatch logic and the FPU instance.

## Interface
- `DEPTH`, 4: response FIFO entries; power of two, ≥ 4.
- `TAG_W`, 4: request/response tag width.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_op` in 2: 00 add, 01 sub, 10 mul, 11 div.
- `req_rm` in 2: rounding mode.
- `req_a`, `req_b` in 32: IEEE-754 single operands.
- `req_tag` in TAG_W: caller tag, returned unchanged.
- `fpu_a`, `fpu_b` out 32; `fpu_sel` out 2; `fpu_rm` out 2; `fpu_start` out 1: drive the FPU.
- `fpu_y` in 32; `fpu_error` in 1; `fpu_overflow` in 1: FPU registered outputs.
- `resp_valid` out 1; `resp_ready` in 1: response handshake.
- `resp_y` out 32; `resp_error`, `resp_overflow` out 1; `resp_tag` out TAG_W.
- `sticky_err` out 1: set by any captured `error` or `overflow`.
- `clr_sticky` in 1: clears `sticky_err`.

## Operation
- Accept on a cycle with `req_valid && req_ready`.
- Issue stage (S1), registered on the accept edge:
  - `fpu_a`/`fpu_b`/`fpu_sel`/`fpu_rm` ← request fields.
  - `fpu_start` ← 1.
  - `s1_tag` ← `req_tag`; `s1_v` ← 1.
- With no accept, `fpu_start` ← 0. Operand and opcode registers hold their values.
- The FPU registers its result on the edge that ends the S1 cycle, and holds outputs while `start` = 0.
- Wait stage (S2): on that same edge, `s2_v` ← `s1_v` and `s2_tag` ← `s1_tag`.
- Capture:
  - While `s2_v` = 1, on the next edge push {`fpu_y`, `fpu_error`, `fpu_overflow`, `s2_tag`} into the FIFO.
  - Pushes happen only for tracked entries. Stale FPU outputs are never captured.
- Credit rule: `req_ready = (count + s1_v + s2_v) < DEPTH`.
  - `count` is the FIFO occupancy.
  - The FIFO therefore never overflows, and no push is ever dropped.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH.
  - `count` is log2(DEPTH)+1 bits.
  - `resp_*` come from the head entry. `resp_valid = (count != 0)`.
  - Pop on `resp_valid && resp_ready`.
- Simultaneous push and pop: allowed in any state, including full-minus-in-flight. `count` is unchanged.
- Sticky flag:
  - `sticky_err` sets on a push with `error | overflow`.
  - `clr_sticky` clears it.
  - If a set and `clr_sticky` occur in the same cycle, set wins.
- Ordering: responses are returned strictly in request order.

## Timing
- Reset values: `req_ready` = 1, `fpu_start` = 0, `fpu_a`/`fpu_b` = 0, `fpu_sel`/`fpu_rm` = 0, `s1_v`/`s2_v` = 0, `count` = 0, pointers = 0, `resp_valid` = 0, `sticky_err` = 0. `resp_*` data values are don't-care while `resp_valid` = 0.
- Latency: accept at edge k → `fpu_start` high in cycle k..k+1 → FPU result valid after edge k+1 → FIFO push at edge k+2 → `resp_valid` high after edge k+2 (2 cycles).
- Throughput: one request per cycle while credits remain. Back-to-back accepts give back-to-back `fpu_start`.
- Backpressure: with `resp_ready` held low, at most DEPTH requests are accepted. `req_ready` then falls, and the in-flight entries drain into the FIFO.
- Reset mid-operation clears all in-flight and buffered entries; no response is produced for them. The FPU shares the same reset.
- `req_ready` is combinational from registered state only. It has no path from `req_valid` or `resp_ready`.

## Configuration
- `FPU_ISSUE_STATS_EN` defined: adds three 16-bit wrapping counters and their output ports:
  - `stat_issued` increments per accept.
  - `stat_error` increments per push with `error`.
  - `stat_ovf` increments per push with `overflow`.
  - All reset to 0 and are cleared by `clr_sticky`; the clear wins over a same-cycle increment.
- Not defined: the counters and their ports are absent. All other behaviour is identical.

## Test plan
- Single add, A=0x3F800000, B=0x40000000, tag=3, `resp_ready`=1 → `fpu_start` for exactly 1 cycle; response 2 cycles after accept; `resp_y`=0x40400000, tag 3, error=0, overflow=0.
- Four back-to-back ops (add/sub/mul/div) with tags 0–3 → four consecutive `fpu_start` cycles; responses in tag order 0,1,2,3 on consecutive cycles.
- `resp_ready`=0, `req_valid` held high with DEPTH=4 → exactly 4 accepts, `req_ready`=0 afterwards; raising `resp_ready` for 1 cycle → one pop and exactly one further accept.
- Div 0x3F800000 / 0x00000000 → response carries the FPU's error/overflow unchanged; `sticky_err`=1; `clr_sticky` in the same cycle as a second error push → `sticky_err` stays 1.
- Assert `reset` with 2 ops in flight and 2 buffered → `resp_valid`=0, `req_ready`=1, `fpu_start`=0 immediately; no responses afterwards.
- With `FPU_ISSUE_STATS_EN`: 5 ops, 1 producing error → `stat_issued`=5, `stat_error`=1; `clr_sticky` → all counters 0.
